// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : FSM state codes, parity-mode codes and a parity helper for the
//               uart_rx_ext receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic parity8(input logic [7:0] data, input logic [7:0] mask);
        return ^(data & mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sampler.sv
// ============================================================================
// Module      : uart_rx_sampler
// Description : Input synchroniser, bit-period counter and sample strobe.
//               UART_RX_MAJORITY_EN selects a 2-of-3 majority sample.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_serial,
    input  logic active,
    input  logic half_point,
    output logic line,
    output logic sample_stb,
    output logic sample_bit
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_PT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_PT = CW'((CLKS_PER_BIT - 1) / 2);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= rx_serial;
            sync2 <= sync1;
        end
    end

    assign line       = sync2;
    assign sample_stb = active && (count == (half_point ? HALF_PT : FULL_PT));

    // Counter wraps at every sample point, so each bit period restarts from 0.
    always_ff @(posedge clk) begin
        if (rst || !active || sample_stb)
            count <= '0;
        else
            count <= count + 1'b1;
    end

`ifdef UART_RX_MAJORITY_EN
    logic hist1;
    logic hist2;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist1 <= 1'b1;
            hist2 <= 1'b1;
        end else begin
            hist1 <= sync2;
            hist2 <= hist1;
        end
    end

    assign sample_bit = (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
`else
    assign sample_bit = sync2;
`endif

endmodule

`default_nettype wire

// File: rtl/uart_rx_ext.sv
// ============================================================================
// Module      : uart_rx_ext
// Description : Parametrised UART receiver with parity, 1/2 stop bits, error
//               flags and valid/ready output. UART_RX_MAJORITY_EN enables the
//               majority-vote sampler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    input  logic [1:0] i_Parity_Mode,
    input  logic       i_Rx_Ready,
    output logic       o_Rx_Valid,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Parity_Err,
    output logic       o_Frame_Err,
    output logic       o_Overrun
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic [7:0] DATA_MASK = 8'((9'd1 << DATA_BITS) - 9'd1);

    logic [2:0] state;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic [1:0] frame_mode;
    logic       par_err_acc;
    logic       frame_err_acc;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    logic       line;
    logic       sample_stb;
    logic       sample_bit;
    logic       parity_on;
    logic       parity_calc;
    logic       load;
    logic       xfer;

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .clk        (i_Clock),
        .rst        (i_Reset),
        .rx_serial  (i_Rx_Serial),
        .active     (state != IDLE),
        .half_point (state == START),
        .line       (line),
        .sample_stb (sample_stb),
        .sample_bit (sample_bit)
    );

    assign parity_on   = (frame_mode == PAR_EVEN) || (frame_mode == PAR_ODD);
    assign parity_calc = parity8(shift_reg, DATA_MASK) ^ sample_bit;
    assign load        = (state == STOP) && sample_stb && (bit_idx == LAST_STOP);
    assign xfer        = rx_valid && i_Rx_Ready;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state         <= IDLE;
            bit_idx       <= '0;
            shift_reg     <= '0;
            frame_mode    <= PAR_NONE;
            par_err_acc   <= 1'b0;
            frame_err_acc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!line)
                        state <= START;
                end
                START: begin
                    if (sample_stb) begin
                        if (!sample_bit) begin
                            state         <= DATA;
                            frame_mode    <= i_Parity_Mode;
                            shift_reg     <= '0;
                            bit_idx       <= '0;
                            par_err_acc   <= 1'b0;
                            frame_err_acc <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (sample_stb) begin
                        shift_reg[bit_idx] <= sample_bit;
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            state   <= parity_on ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (sample_stb) begin
                        par_err_acc <= (frame_mode == PAR_ODD) ? ~parity_calc : parity_calc;
                        state       <= STOP;
                    end
                end
                STOP: begin
                    if (sample_stb) begin
                        frame_err_acc <= frame_err_acc | ~sample_bit;
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A completion that coincides with a transfer replaces a consumed word, so no overrun.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_valid   <= 1'b0;
            rx_byte    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else if (load) begin
            rx_valid   <= 1'b1;
            rx_byte    <= shift_reg;
            parity_err <= par_err_acc;
            frame_err  <= frame_err_acc | ~sample_bit;
            overrun    <= rx_valid && !i_Rx_Ready;
        end else if (xfer) begin
            rx_valid <= 1'b0;
        end
    end

    assign o_Rx_Valid   = rx_valid;
    assign o_Rx_Byte    = rx_byte;
    assign o_Parity_Err = parity_err;
    assign o_Frame_Err  = frame_err;
    assign o_Overrun    = overrun;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
// ============================================================================
// Module      : tb_uart_rx_ext
// Description : Directed self-checking bench for uart_rx_ext (CLKS_PER_BIT=16);
//               the glitch-filter step is built only with UART_RX_MAJORITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ext;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [1:0] pm  = 2'b00;
    logic       rdy = 1'b1;

    logic       v8, pe8, fe8, ov8;
    logic [7:0] b8;
    logic       v7, pe7, fe7, ov7;
    logic [7:0] b7;
    logic       v2, pe2, fe2, ov2;
    logic [7:0] b2;

    int passed = 0;
    int total  = 0;

    int         acc8 = 0, acc7 = 0, acc2 = 0;
    logic [7:0] lb8 = 8'h00, lb7 = 8'h00, lb2 = 8'h00;
    logic       lpe8 = 1'b0, lfe8 = 1'b0, lov8 = 1'b0;
    logic       lpe7 = 1'b0, lfe7 = 1'b0;
    logic       lpe2 = 1'b0, lfe2 = 1'b0;

    always #5 clk = ~clk;

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(1)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx), .i_Parity_Mode(pm),
        .i_Rx_Ready(rdy), .o_Rx_Valid(v8), .o_Rx_Byte(b8),
        .o_Parity_Err(pe8), .o_Frame_Err(fe8), .o_Overrun(ov8));

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .STOP_BITS(1)) u_7b (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx), .i_Parity_Mode(pm),
        .i_Rx_Ready(rdy), .o_Rx_Valid(v7), .o_Rx_Byte(b7),
        .o_Parity_Err(pe7), .o_Frame_Err(fe7), .o_Overrun(ov7));

    uart_rx_ext #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .STOP_BITS(2)) u_2s (
        .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx), .i_Parity_Mode(pm),
        .i_Rx_Ready(rdy), .o_Rx_Valid(v2), .o_Rx_Byte(b2),
        .o_Parity_Err(pe2), .o_Frame_Err(fe2), .o_Overrun(ov2));

    // Record every accepted word per instance.
    always @(negedge clk) begin
        if (v8 && rdy) begin
            acc8 <= acc8 + 1; lb8 <= b8; lpe8 <= pe8; lfe8 <= fe8; lov8 <= ov8;
        end
        if (v7 && rdy) begin
            acc7 <= acc7 + 1; lb7 <= b7; lpe7 <= pe7; lfe7 <= fe7;
        end
        if (v2 && rdy) begin
            acc2 <= acc2 + 1; lb2 <= b2; lpe2 <= pe2; lfe2 <= fe2;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input int par,
                              input logic s1, input logic s2, input int nstop);
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(data[i]);
        if (par >= 0) send_bit(par[0]);
        send_bit(s1);
        if (nstop == 2) send_bit(s2);
        rx = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    int c8, c7, c2;

    initial begin
        // Reset state
        tick(3);
        check("rst_valid", {7'd0, v8}, 8'h00);
        check("rst_byte", b8, 8'h00);
        check("rst_flags", {5'd0, pe8, fe8, ov8}, 8'h00);
        check("rst_state", {5'd0, u_8n1.state}, {5'd0, IDLE});
        do_reset();
        check("rst_rel_valid", {7'd0, v8}, 8'h00);

        // 8N1 0xA5
        c8 = acc8;
        send_frame(8'hA5, 8, -1, 1'b1, 1'b1, 1);
        tick(2 * CPB);
        check("a5_count", 8'(acc8 - c8), 8'd1);
        check("a5_byte", lb8, 8'hA5);
        check("a5_flags", {5'd0, lpe8, lfe8, lov8}, 8'h00);
        check("a5_valid_low", {7'd0, v8}, 8'h00);

        // 7 data bits, even parity, 0x03 with parity 1 then 0
        do_reset();
        pm = PAR_EVEN;
        c7 = acc7;
        send_frame(8'h03, 7, 1, 1'b1, 1'b1, 1);
        tick(3 * CPB);
        check("par1_count", 8'(acc7 - c7), 8'd1);
        check("par1_byte", lb7, 8'h03);
        check("par1_perr", {7'd0, lpe7}, 8'h01);
        check("par1_ferr", {7'd0, lfe7}, 8'h00);
        c7 = acc7;
        send_frame(8'h03, 7, 0, 1'b1, 1'b1, 1);
        tick(3 * CPB);
        check("par0_count", 8'(acc7 - c7), 8'd1);
        check("par0_byte", lb7, 8'h03);
        check("par0_perr", {7'd0, lpe7}, 8'h00);
        pm = PAR_NONE;

        // Two stop bits, second stop driven low
        do_reset();
        c2 = acc2;
        send_frame(8'h3C, 8, -1, 1'b1, 1'b0, 2);
        tick(2 * CPB);
        check("stop2_count", 8'(acc2 - c2), 8'd1);
        check("stop2_byte", lb2, 8'h3C);
        check("stop2_ferr", {7'd0, lfe2}, 8'h01);
        check("stop2_perr", {7'd0, lpe2}, 8'h00);

        // Short low pulse is rejected as a false start
        do_reset();
        c8 = acc8;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * CPB);
        check("glitch_count", 8'(acc8 - c8), 8'd0);
        check("glitch_valid", {7'd0, v8}, 8'h00);
        check("glitch_state", {5'd0, u_8n1.state}, {5'd0, IDLE});

`ifdef UART_RX_MAJORITY_EN
        // One-cycle high spike inside data bit 3 of 0x00 is voted out
        do_reset();
        c8 = acc8;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0);
        rx = 1'b0; tick(9);
        rx = 1'b1; tick(1);
        rx = 1'b0; tick(6);
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_bit(1'b1);
        tick(2 * CPB);
        check("maj_count", 8'(acc8 - c8), 8'd1);
        check("maj_byte", lb8, 8'h00);
        check("maj_flags", {6'd0, lpe8, lfe8}, 8'h00);
`endif

        // Overrun: consumer stalled, back-to-back frames
        do_reset();
        rdy = 1'b0;
        send_frame(8'h11, 8, -1, 1'b1, 1'b1, 1);
        check("ovr_first_valid", {7'd0, v8}, 8'h01);
        check("ovr_first_byte", b8, 8'h11);
        check("ovr_first_ov", {7'd0, ov8}, 8'h00);
        send_frame(8'h22, 8, -1, 1'b1, 1'b1, 1);
        tick(2);
        check("ovr_valid", {7'd0, v8}, 8'h01);
        check("ovr_byte", b8, 8'h22);
        check("ovr_flag", {7'd0, ov8}, 8'h01);
        rdy = 1'b1;
        tick(1);
        check("ovr_accept_valid", {7'd0, v8}, 8'h00);
        tick(CPB);

        // Reset during data bit 4 of 0xFF, then a clean 0x5A
        do_reset();
        c8 = acc8;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(8 + 5 * CPB);
        check("abort_count", 8'(acc8 - c8), 8'd0);
        check("abort_valid", {7'd0, v8}, 8'h00);
        check("abort_byte", b8, 8'h00);
        send_frame(8'h5A, 8, -1, 1'b1, 1'b1, 1);
        tick(2 * CPB);
        check("clean_count", 8'(acc8 - c8), 8'd1);
        check("clean_byte", lb8, 8'h5A);
        check("clean_flags", {5'd0, lpe8, lfe8, lov8}, 8'h00);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
